imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader for the pipelined MIPS core. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words into the instruction memory that the fetch stage reads, then verifies a trailing checksum word. The pipeline is held in reset (`core_rst_n` low) until a load completes with a matching checksum.

## Interface
- `ADDR_WIDTH`, default 8: instruction-memory word-address width. Capacity is `2**ADDR_WIDTH` words.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: reset, asynchronous, active-low.
- `start  in  1`: begin a load session. Sampled in IDLE, RUN and ERROR; ignored in LOAD and CHECK.
- `len_words  in  ADDR_WIDTH+1`: number of instruction words to load, latched when `start` is accepted.
- `byte_valid  in  1`: source presents `byte_data`.
- `byte_data  in  8`: stream byte.
- `byte_ready  out  1`: loader accepts a byte. A transfer occurs when `byte_valid && byte_ready` at a rising edge.
- `imem_wr_en  out  1`: instruction-memory write strobe.
- `imem_wr_addr  out  ADDR_WIDTH`: word address.
- `imem_wr_data  out  32`: instruction word.
- `core_rst_n  out  1`: active-low reset to the pipeline. Low unless in RUN.
- `busy  out  1`: high in LOAD and CHECK.
- `done  out  1`: one-cycle pulse when a session ends.
- `err  out  1`: sticky result of the last session. 1 means bad length or checksum mismatch.

## Operation
- States: IDLE, LOAD, CHECK, RUN, ERROR. Reset state is IDLE.
- IDLE/RUN/ERROR + `start`:
  - Latch `len_words`; clear `word_cnt`, `byte_cnt` and `sum`; clear `err`.
  - If `len_words > 2**ADDR_WIDTH`, go to ERROR with a `done` pulse and `err=1`.
  - Else if `len_words==0`, go to CHECK.
  - Else go to LOAD.
- LOAD:
  - `byte_ready=1`. Each transfer places the byte at lane `byte_cnt` of the assembly register (first byte → bits 7:0, fourth → bits 31:24), then `byte_cnt++` (2-bit, wraps).
  - On the 4th byte:
    - Issue the write: `imem_wr_addr=word_cnt`, `imem_wr_data` = assembled word.
    - `sum += word`, modulo 2^32.
    - `word_cnt++`.
    - If `word_cnt+1 == len`, go to CHECK.
- CHECK:
  - `byte_ready=1`. Assemble 4 bytes the same way into the checksum word.
  - On the 4th byte: if checksum equals `sum`, go to RUN with `err=0`; else go to ERROR with `err=1`. `done` pulses either way.
- RUN: `core_rst_n=1`. `start` drops `core_rst_n` in the next cycle and begins a new session.
- ERROR: `core_rst_n=0` and the core stays held. Only `start` or `rst` leaves this state.
- No writes occur outside LOAD. `byte_valid` gaps of any length are tolerated, and bytes are never lost or duplicated.

## Timing
- Reset values:
  - state IDLE
  - `byte_ready=0`, `imem_wr_en=0`, `imem_wr_addr=0`, `imem_wr_data=0`
  - `core_rst_n=0`, `busy=0`, `done=0`, `err=0`
- All outputs are registered, except `byte_ready`, `busy` and `core_rst_n`, which are decoded from the state register.
- Write latency: `imem_wr_en` is high for exactly one cycle, the cycle after the edge that accepts the 4th byte of a word.
- `byte_ready` stays high across the LOAD→CHECK transition. Back-to-back bytes sustain one byte per clock.
- `done` is high the cycle after the edge that accepts the last checksum byte. The new state (RUN/ERROR) and `err` are valid in that same cycle.
- Start to first `byte_ready`: 1 cycle.
- Assertion of `rst` mid-session aborts immediately: all outputs take their reset values and partial words are discarded.

## Structure
- Shared package: state encoding enum, `BYTES_PER_WORD=4`.
- One natural sub-module, `word_assembler`: byte lane shifter plus 2-bit byte counter, emitting `word_valid` and `word`. It is reused by the LOAD and CHECK paths.
- The FSM, word counter and checksum accumulator live in the top.

## Test plan
- Reset:
  - Stimulus: hold `rst=0` while driving `byte_valid=1`.
  - Required: `byte_ready=0`, `core_rst_n=0`, no `imem_wr_en`, `err=0`.
- Two-word load:
  - Stimulus: `len=2`, bytes 78 56 34 12 EF BE AD DE, then checksum bytes 67 15 E2 F0.
  - Required: writes addr0=0x12345678 and addr1=0xDEADBEEF; `done` pulse; `err=0`; `core_rst_n=1`.
- Checksum wrap:
  - Stimulus: words 0xFFFFFFFF and 0x00000002, checksum 0x00000001.
  - Required: RUN.
  - Repeat with checksum 0x00000000. Required: ERROR, `err=1`, `core_rst_n` stays 0.
- Boundary lengths:
  - `len=0` with checksum 00 00 00 00 → no writes, RUN after 4 bytes.
  - `len=257` at `ADDR_WIDTH=8` → immediate `done`, `err=1`, no `byte_ready`.
  - `len=256` → last write to addr 0xFF.
- Flow control and `start` handling:
  - Random `byte_valid` gaps, with `start` pulsed during LOAD (must be ignored). Required: identical writes to the gap-free run.
  - `start` in RUN → `core_rst_n` low the next cycle, and the reload proceeds.
- Reset mid-load:
  - Stimulus: assert `rst` after 6 bytes of a 2-word load, then restart with `len=1`.
  - Required: first write goes to addr0 with only the new bytes.

Source files
------------

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the boot-time instruction
//               memory loader (state encoding, word geometry).
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  // Stream bytes that make up one little-endian instruction word
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

  // Loader session states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Collects stream bytes into a little-endian 32-bit word. The
//               first byte lands in bits 7:0, the fourth in bits 31:24. The
//               completed word is presented combinationally together with
//               o_word_valid during the transfer of its last byte.
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic        i_clear,      // restart assembly at lane 0
  input  logic        i_byte_en,    // a byte transfer happens this cycle
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [LANE_W-1:0] r_byte_cnt;
  logic [31:0]       r_lanes;
  logic              w_last_lane;

  assign w_last_lane  = (r_byte_cnt == LANE_W'(BYTES_PER_WORD - 1));
  assign o_word_valid = i_byte_en && w_last_lane;

  // Completed word: lanes already held plus the byte arriving now in the top lane
  always_comb begin
    o_word = r_lanes;
    o_word[8*(BYTES_PER_WORD-1) +: 8] = i_byte;
  end

  // Lane register and byte counter; the counter wraps so the next word starts at lane 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_cnt <= '0;
      r_lanes    <= '0;
    end else if (i_clear) begin
      r_byte_cnt <= '0;
      r_lanes    <= '0;
    end else if (i_byte_en) begin
      r_lanes[{r_byte_cnt, 3'b000} +: 8] <= i_byte;
      r_byte_cnt                         <= r_byte_cnt + 1'b1;
    end
  end

endmodule : word_assembler
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time program loader. Streams bytes into instruction
//               words, writes them to instruction memory, verifies a trailing
//               checksum word and releases the pipeline reset on success.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,          // asynchronous, active-low
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len_words,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_wr_en,
  output logic [ADDR_WIDTH-1:0] imem_wr_addr,
  output logic [31:0]           imem_wr_data,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // Memory capacity in words, expressed in the width of len_words
  localparam logic [ADDR_WIDTH:0] c_CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_word_cnt;
  logic [31:0]           r_sum;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [31:0]           r_wr_data;
  logic                  r_done;
  logic                  r_err;

  logic                  w_in_session;
  logic                  w_can_start;
  logic                  w_start_ok;
  logic                  w_xfer;
  logic                  w_len_bad;
  logic                  w_len_zero;
  logic [ADDR_WIDTH:0]   w_word_cnt_inc;
  logic                  w_last_word;
  logic                  w_word_valid;
  logic [31:0]           w_word;
  logic                  w_sum_match;

  // State-decoded outputs; byte_ready stays high straight through LOAD into CHECK
  assign w_in_session = (r_state == ST_LOAD) || (r_state == ST_CHECK);
  assign byte_ready   = w_in_session;
  assign busy         = w_in_session;
  assign core_rst_n   = (r_state == ST_RUN);

  assign w_can_start    = (r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_ERROR);
  assign w_start_ok     = start && w_can_start;
  assign w_xfer         = byte_valid && byte_ready;
  assign w_len_bad      = (len_words > c_CAPACITY);
  assign w_len_zero     = (len_words == '0);
  assign w_word_cnt_inc = r_word_cnt + 1'b1;
  assign w_last_word    = (w_word_cnt_inc == r_len);
  assign w_sum_match    = (w_word == r_sum);

  // One assembler serves both the program words and the checksum word
  word_assembler u_word_assembler (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_start_ok),
    .i_byte_en    (w_xfer),
    .i_byte       (byte_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start) begin
          if (w_len_bad) begin
            w_next = ST_ERROR;
          end else if (w_len_zero) begin
            w_next = ST_CHECK;
          end else begin
            w_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (w_word_valid && w_last_word) begin
          w_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_word_valid) begin
          w_next = w_sum_match ? ST_RUN : ST_ERROR;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Session bookkeeping, memory write port and result flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len      <= '0;
      r_word_cnt <= '0;
      r_sum      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      if (w_start_ok) begin
        r_len      <= len_words;
        r_word_cnt <= '0;
        r_sum      <= '0;
        r_err      <= w_len_bad;
        r_done     <= w_len_bad;
      end
      if ((r_state == ST_LOAD) && w_word_valid) begin
        r_wr_en    <= 1'b1;
        r_wr_addr  <= r_word_cnt[ADDR_WIDTH-1:0];
        r_wr_data  <= w_word;
        r_sum      <= r_sum + w_word;
        r_word_cnt <= w_word_cnt_inc;
      end
      if ((r_state == ST_CHECK) && w_word_valid) begin
        r_done <= 1'b1;
        r_err  <= !w_sum_match;
      end
    end
  end

  assign imem_wr_en   = r_wr_en;
  assign imem_wr_addr = r_wr_addr;
  assign imem_wr_data = r_wr_data;
  assign done         = r_done;
  assign err          = r_err;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader: a table of load sessions
//               with hand-computed checksums plus directed sequences for
//               length boundaries, restart from RUN and reset mid-load.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   len_words;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_wr_en;
  logic [AW-1:0] imem_wr_addr;
  logic [31:0]   imem_wr_data;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic          err;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .len_words    (len_words),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_wr_en   (imem_wr_en),
    .imem_wr_addr (imem_wr_addr),
    .imem_wr_data (imem_wr_data),
    .core_rst_n   (core_rst_n),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] wr_addr_q [$];
  logic [31:0]   wr_data_q [$];
  logic [31:0]   wbuf [0:255];

  typedef struct {
    int          len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] cks;
    bit          gap;
    bit          exp_err;
  } vec_t;

  vec_t vecs [6];

  // Record every memory write strobe seen mid-cycle
  always @(negedge clk) begin
    if (imem_wr_en === 1'b1) begin
      wr_addr_q.push_back(imem_wr_addr);
      wr_data_q.push_back(imem_wr_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one byte and hold it until the loader takes it
  task automatic send_byte(input logic [7:0] b, input bit gap, input bit poke_start);
    int t;
    bit rdy;
    if (gap) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    if (poke_start) begin
      len_words = 9'd5;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    t   = 0;
    rdy = 1'b0;
    while (!rdy && t < 100) begin
      @(negedge clk);
      rdy = byte_ready;
      @(posedge clk); #1;
      t++;
    end
    byte_valid = 1'b0;
    chk("byte_accepted", {31'b0, rdy}, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap, input bit poke_start);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], gap, poke_start && (k == 1));
    end
  endtask

  task automatic do_start(input logic [AW:0] l);
    len_words = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // Full session: start, wbuf[0..len-1], checksum, then result and write checks
  task automatic run_session(input int len, input logic [31:0] cks, input bit gap,
                             input bit exp_err, input string tag);
    wr_addr_q.delete();
    wr_data_q.delete();
    do_start(len[AW:0]);
    @(negedge clk);
    chk({tag, ".ready_after_start"}, {31'b0, byte_ready}, 32'd1);
    chk({tag, ".busy_after_start"}, {31'b0, busy}, 32'd1);
    chk({tag, ".core_rst_n_held"}, {31'b0, core_rst_n}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < len; i++) begin
      send_word(wbuf[i], gap, gap && (i == 1));
    end
    send_word(cks, gap, 1'b0);
    @(negedge clk);
    chk({tag, ".done"}, {31'b0, done}, 32'd1);
    chk({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
    chk({tag, ".core_rst_n"}, {31'b0, core_rst_n}, {31'b0, !exp_err});
    chk({tag, ".ready_off"}, {31'b0, byte_ready}, 32'd0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, ".wr_count"}, wr_data_q.size(), len);
    for (int i = 0; i < len && i < wr_data_q.size(); i++) begin
      chk({tag, ".wr_addr"}, {24'b0, wr_addr_q[i]}, i);
      chk({tag, ".wr_data"}, wr_data_q[i], wbuf[i]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sum;

    vecs[0] = '{len: 2, w0: 32'h12345678, w1: 32'hDEADBEEF, cks: 32'hF0E21567, gap: 1'b0, exp_err: 1'b0};
    vecs[1] = '{len: 2, w0: 32'hFFFFFFFF, w1: 32'h00000002, cks: 32'h00000001, gap: 1'b0, exp_err: 1'b0};
    vecs[2] = '{len: 2, w0: 32'hFFFFFFFF, w1: 32'h00000002, cks: 32'h00000000, gap: 1'b0, exp_err: 1'b1};
    vecs[3] = '{len: 0, w0: 32'h0,        w1: 32'h0,        cks: 32'h00000000, gap: 1'b0, exp_err: 1'b0};
    vecs[4] = '{len: 2, w0: 32'h12345678, w1: 32'hDEADBEEF, cks: 32'hF0E21567, gap: 1'b1, exp_err: 1'b0};
    vecs[5] = '{len: 1, w0: 32'h11111111, w1: 32'h0,        cks: 32'h22222222, gap: 1'b0, exp_err: 1'b1};

    // Reset held with a source already offering data
    rst        = 1'b0;
    start      = 1'b0;
    len_words  = '0;
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.byte_ready", {31'b0, byte_ready}, 32'd0);
    chk("rst.core_rst_n", {31'b0, core_rst_n}, 32'd0);
    chk("rst.wr_en", {31'b0, imem_wr_en}, 32'd0);
    chk("rst.wr_addr", {24'b0, imem_wr_addr}, 32'd0);
    chk("rst.wr_data", imem_wr_data, 32'd0);
    chk("rst.err", {31'b0, err}, 32'd0);
    chk("rst.done", {31'b0, done}, 32'd0);
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.no_writes", wr_data_q.size(), 0);
    byte_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle.core_rst_n", {31'b0, core_rst_n}, 32'd0);
    chk("idle.byte_ready", {31'b0, byte_ready}, 32'd0);
    @(posedge clk); #1;

    // Table of sessions, entered from IDLE, RUN and ERROR in turn
    for (int v = 0; v < 6; v++) begin
      wbuf[0] = vecs[v].w0;
      wbuf[1] = vecs[v].w1;
      run_session(vecs[v].len, vecs[v].cks, vecs[v].gap, vecs[v].exp_err, $sformatf("vec%0d", v));
      if (vecs[v].exp_err) begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk($sformatf("vec%0d.error_hold", v), {30'b0, core_rst_n, byte_ready}, 32'd0);
        chk($sformatf("vec%0d.err_sticky", v), {31'b0, err}, 32'd1);
        @(posedge clk); #1;
      end
    end

    // Oversized length: immediate failure, no stream accepted
    wr_data_q.delete();
    do_start(9'd257);
    @(negedge clk);
    chk("len257.done", {31'b0, done}, 32'd1);
    chk("len257.err", {31'b0, err}, 32'd1);
    chk("len257.byte_ready", {31'b0, byte_ready}, 32'd0);
    chk("len257.core_rst_n", {31'b0, core_rst_n}, 32'd0);
    @(negedge clk);
    chk("len257.done_pulse", {31'b0, done}, 32'd0);
    chk("len257.byte_ready2", {31'b0, byte_ready}, 32'd0);
    chk("len257.no_writes", wr_data_q.size(), 0);
    @(posedge clk); #1;

    // Full-capacity load with a modelled checksum
    sum = 32'h0;
    for (int i = 0; i < 256; i++) begin
      wbuf[i] = (i * 32'h01010101) ^ 32'hA5000000 ^ (i << 20);
      sum     = sum + wbuf[i];
    end
    run_session(256, sum, 1'b0, 1'b0, "len256");
    chk("len256.last_addr", (wr_addr_q.size() == 256) ? {24'b0, wr_addr_q[255]} : 32'hFFFFFFFF, 32'h000000FF);

    // Restart from RUN, then reset after six bytes of a two-word load
    @(negedge clk);
    chk("run.core_rst_n", {31'b0, core_rst_n}, 32'd1);
    @(posedge clk); #1;
    wr_data_q.delete();
    wr_addr_q.delete();
    do_start(9'd2);
    @(negedge clk);
    chk("restart.core_rst_n", {31'b0, core_rst_n}, 32'd0);
    chk("restart.byte_ready", {31'b0, byte_ready}, 32'd1);
    @(posedge clk); #1;
    send_word(32'h11223344, 1'b0, 1'b0);
    send_byte(8'h88, 1'b0, 1'b0);
    send_byte(8'h77, 1'b0, 1'b0);
    chk("midrst.first_write", wr_data_q.size(), 1);
    rst = 1'b0;
    #2;
    chk("midrst.byte_ready", {31'b0, byte_ready}, 32'd0);
    chk("midrst.busy", {31'b0, busy}, 32'd0);
    chk("midrst.wr_addr", {24'b0, imem_wr_addr}, 32'd0);
    chk("midrst.wr_data", imem_wr_data, 32'd0);
    chk("midrst.core_rst_n", {31'b0, core_rst_n}, 32'd0);
    chk("midrst.err", {31'b0, err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    wbuf[0] = 32'hCAFEBABE;
    run_session(1, 32'hCAFEBABE, 1'b0, 1'b0, "reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_imem_loader
`default_nettype wire
